// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per clock, LSB first.
// Optional signed-overflow output Ovf is enabled by defining SUB_SIGNED_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
`ifdef SUB_SIGNED_OVF_EN
  output logic             Ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic             d_bit;
  logic             br_next;
`ifdef SUB_SIGNED_OVF_EN
  logic             a_msb_q;
  logic             b_msb_q;
`endif

  assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Diff    <= '0;
      Bout    <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      Ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            br_q    <= Bin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
`ifdef SUB_SIGNED_OVF_EN
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
`endif
          end
        end
        StRun: begin
          // Result bits enter at the MSB so the word is aligned after WIDTH shifts.
          res_q <= {d_bit, res_q[WIDTH-1:1]};
          br_q  <= br_next;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          Diff    <= res_q;
          Bout    <= br_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
`ifdef SUB_SIGNED_OVF_EN
          Ovf     <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_q[WIDTH-1]);
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised self-checking bench for serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_SIGNED_OVF_EN
  logic         ovf;
  logic         last_ovf;
`endif

  int           n_vec;
  int           n_err;
  logic [W-1:0] last_diff;
  logic         last_bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (a_in),
    .B    (b_in),
    .Bin  (bin_in),
`ifdef SUB_SIGNED_OVF_EN
    .Ovf  (ovf),
`endif
    .busy (busy),
    .done (done),
    .Diff (diff),
    .Bout (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision unsigned subtraction, borrow is the bit above the result.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  endfunction

  // Entered at a negedge where the DUT is idle; returns at the negedge where done is high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input bit inj);
    logic [W:0] exp_res;
    int         cycles;
    int         busy_cnt;
    exp_res = ref_sub(a, b, bin);
    a_in   = a;
    b_in   = b;
    bin_in = bin;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_low_after_start", done, 0);
    cycles   = 1;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      check("diff_hold", diff, last_diff);
      check("bout_hold", bout, last_bout);
      @(negedge clk);
      cycles++;
      a_in   = W'($urandom);
      b_in   = W'($urandom);
      bin_in = 1'($urandom);
      start  = inj && (cycles <= int'(W)) && ($urandom_range(1) == 1);
    end
    start = 1'b0;
    if (!done) check("done_timeout", 0, 1);
    check("latency", cycles, W + 2);
    check("busy_cycles", busy_cnt, W + 1);
    check("busy_at_done", busy, 0);
    check("diff", diff, exp_res[W-1:0]);
    check("bout", bout, exp_res[W]);
    last_diff = exp_res[W-1:0];
    last_bout = exp_res[W];
`ifdef SUB_SIGNED_OVF_EN
    last_ovf = (a[W-1] ^ b[W-1]) & (a[W-1] ^ exp_res[W-1]);
    check("ovf", ovf, last_ovf);
`endif
  endtask

  initial begin
    bit seen_done;
    n_vec     = 0;
    n_err     = 0;
    last_diff = '0;
    last_bout = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    a_in      = '0;
    b_in      = '0;
    bin_in    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
`ifdef SUB_SIGNED_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;

    do_op(4'b0101, 4'b0011, 1'b0, 1'b0);
    do_op(4'b0011, 4'b0101, 1'b0, 1'b0);
    do_op(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Start pulse with different operands during RUN must be ignored.
    a_in = 4'b1111; b_in = 4'b0001; bin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in = 4'b0000; b_in = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        check("guard_diff", diff, 4'b1110);
        check("guard_bout", bout, 0);
        seen_done = 1'b1;
      end
      @(negedge clk);
      if (done && seen_done) check("guard_single_done", 1, 0);
    end
    check("guard_done_seen", seen_done, 1);
    last_diff = 4'b1110;
    last_bout = 1'b0;
`ifdef SUB_SIGNED_OVF_EN
    last_ovf = 1'b0;
`endif

    // Reset in the third RUN cycle aborts without a done pulse.
    a_in = 4'b1001; b_in = 4'b0110; bin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", seen_done, 0);
    last_diff = '0;
    last_bout = 1'b0;
    do_op(4'b1010, 4'b0101, 1'b1, 1'b0);

    do_op(4'b0111, 4'b1000, 1'b0, 1'b0);
    do_op(4'b0101, 4'b0011, 1'b0, 1'b0);

    // Exhaustive, back-to-back: each op starts in the done cycle of the previous one.
    for (int bi = 0; bi < 2; bi++)
      for (int ai = 0; ai < 16; ai++)
        for (int bb = 0; bb < 16; bb++)
          do_op(W'(ai), W'(bb), 1'(bi), 1'b0);

    for (int i = 0; i < 60; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);

    @(negedge clk);
    check("done_single_pulse", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
